// File: rtl/tcp_pkg.sv
// Shared constants, header field offsets, parser state and tuple type for the
// TCP payload extractor.
package tcp_pkg;

  // Protocol constants
  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_TCP   = 8'd6;
  localparam logic [15:0] ETH_HDR_LEN    = 16'd14;
  localparam logic [15:0] OFF_MAX        = 16'hFFFF;

  // Absolute frame offsets (Ethernet + IPv4 fixed header)
  localparam logic [15:0] OFF_ETYPE_HI   = 16'd12;
  localparam logic [15:0] OFF_ETYPE_LO   = 16'd13;
  localparam logic [15:0] OFF_IP_VIHL    = 16'd14;
  localparam logic [15:0] OFF_IP_LEN_HI  = 16'd16;
  localparam logic [15:0] OFF_IP_LEN_LO  = 16'd17;
  localparam logic [15:0] OFF_IP_PROTO   = 16'd23;
  localparam logic [15:0] OFF_IP_SRC_FST = 16'd26;
  localparam logic [15:0] OFF_IP_SRC_LST = 16'd29;
  localparam logic [15:0] OFF_IP_DST_FST = 16'd30;
  localparam logic [15:0] OFF_IP_DST_LST = 16'd33;

  // Offsets relative to the start of the TCP header
  localparam logic [15:0] TCP_SPORT_HI   = 16'd0;
  localparam logic [15:0] TCP_SPORT_LO   = 16'd1;
  localparam logic [15:0] TCP_DPORT_HI   = 16'd2;
  localparam logic [15:0] TCP_DPORT_LO   = 16'd3;
  localparam logic [15:0] TCP_DOFF       = 16'd12;

  // Minimum legal header lengths in 32-bit words
  localparam logic [3:0]  MIN_HDR_WORDS  = 4'd5;
  localparam logic [3:0]  IP_VERSION_4   = 4'd4;

  typedef enum logic [2:0] {
    StIdle,
    StEth,
    StIp,
    StTcp,
    StPayload,
    StDrop
  } tcp_state_e;

  typedef struct packed {
    logic [31:0] src_ip;
    logic [15:0] src_port;
    logic [31:0] dst_ip;
    logic [15:0] dst_port;
  } tcp_tuple_t;

  // Header length fields count 32-bit words; convert to a byte count.
  function automatic logic [15:0] words_to_bytes(input logic [3:0] words);
    return {10'd0, words, 2'b00};
  endfunction

endpackage

// File: rtl/tcp_if.sv
// Frame byte stream in, matched payload bytes out.
interface tcp_if;

  logic       dataValid;
  logic [7:0] data;
  logic       newpkt;
  logic       outDataMatchA;
  logic       outDataMatchB;
  logic [7:0] outData;

  // Frame source side
  modport master (
    output dataValid, data, newpkt,
    input  outDataMatchA, outDataMatchB, outData
  );

  // Extractor side
  modport slave (
    input  dataValid, data, newpkt,
    output outDataMatchA, outDataMatchB, outData
  );

endinterface

// File: rtl/tcp_tuple_match.sv
// Compares the 4-tuple captured from the current frame against one configured tuple.
module tcp_tuple_match
  import tcp_pkg::*;
(
  input  tcp_tuple_t cap_i,
  input  tcp_tuple_t cfg_i,
  output logic       match_o
);

  logic src_ip_eq;
  logic src_port_eq;
  logic dst_ip_eq;
  logic dst_port_eq;

  // Field-wise equality; every field must agree for a match
  always_comb begin
    src_ip_eq   = (cap_i.src_ip   == cfg_i.src_ip);
    src_port_eq = (cap_i.src_port == cfg_i.src_port);
    dst_ip_eq   = (cap_i.dst_ip   == cfg_i.dst_ip);
    dst_port_eq = (cap_i.dst_port == cfg_i.dst_port);
    match_o     = src_ip_eq && src_port_eq && dst_ip_eq && dst_port_eq;
  end

endmodule

// File: rtl/tcp.sv
// TCP payload extractor: walks Ethernet/IPv4/TCP headers one byte per valid
// cycle and forwards payload bytes of frames matching tuple A and/or B.
module tcp
  import tcp_pkg::*;
#(
  parameter logic [15:0] port = 16'd80,
  parameter logic [47:0] mac  = 48'h000000000000
) (
  input  logic        CLOCK,
  input  logic        reset,
  input  logic [31:0] tcpA_src_ip,
  input  logic [15:0] tcpA_src_port,
  input  logic [31:0] tcpA_dst_ip,
  input  logic [15:0] tcpA_dst_port,
  input  logic [31:0] tcpB_src_ip,
  input  logic [15:0] tcpB_src_port,
  input  logic [31:0] tcpB_dst_ip,
  input  logic [15:0] tcpB_dst_port,
  tcp_if.slave        bus
);

  // port/mac are configuration only; reject obviously broken values at elaboration.
  if (port == 16'd0 || mac[40]) begin : g_cfg_check
    $error("tcp: port must be non-zero and mac must be unicast");
  end

  tcp_state_e  st_q, st_d;
  logic [15:0] off_q, off_d;
  logic [7:0]  etype_hi_q, etype_hi_d;
  logic [3:0]  ihl_q, ihl_d;
  logic [15:0] tot_len_q, tot_len_d;
  logic [3:0]  doff_q, doff_d;
  tcp_tuple_t  cap_q, cap_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        out_a_q, out_a_d;
  logic        out_b_q, out_b_d;

  tcp_tuple_t  cfg_a, cfg_b;
  logic        match_a, match_b;

  tcp_state_e  cur_st;
  logic [15:0] cur_off;
  logic [15:0] tcp_start;
  logic [15:0] payload_start;
  logic [15:0] tcp_rel;
  logic [16:0] ip_end;

  assign cfg_a = {tcpA_src_ip, tcpA_src_port, tcpA_dst_ip, tcpA_dst_port};
  assign cfg_b = {tcpB_src_ip, tcpB_src_port, tcpB_dst_ip, tcpB_dst_port};

  tcp_tuple_match u_match_a (
    .cap_i   (cap_q),
    .cfg_i   (cfg_a),
    .match_o (match_a)
  );

  tcp_tuple_match u_match_b (
    .cap_i   (cap_q),
    .cfg_i   (cfg_b),
    .match_o (match_b)
  );

  // Header-derived boundaries; ip_end needs 17 bits since 14 + 0xFFFF overflows 16
  always_comb begin
    tcp_start     = ETH_HDR_LEN + words_to_bytes(ihl_q);
    payload_start = tcp_start + words_to_bytes(doff_q);
    ip_end        = {1'b0, ETH_HDR_LEN} + {1'b0, tot_len_q};
  end

  // Parser next-state: consumes one byte per valid cycle
  always_comb begin
    st_d       = st_q;
    off_d      = off_q;
    etype_hi_d = etype_hi_q;
    ihl_d      = ihl_q;
    tot_len_d  = tot_len_q;
    doff_d     = doff_q;
    cap_d      = cap_q;
    out_data_d = out_data_q;
    out_a_d    = 1'b0;
    out_b_d    = 1'b0;
    cur_st     = st_q;
    cur_off    = off_q;
    tcp_rel    = '0;

    if (bus.dataValid) begin
      // newpkt restarts parsing on this very byte, aborting any frame in flight
      if (bus.newpkt) begin
        cur_st  = StEth;
        cur_off = '0;
      end
      off_d   = (cur_off == OFF_MAX) ? OFF_MAX : cur_off + 16'd1;
      st_d    = cur_st;
      tcp_rel = cur_off - tcp_start;

      case (cur_st)
        StEth: begin
          if (cur_off == OFF_ETYPE_HI) etype_hi_d = bus.data;
          if (cur_off == OFF_ETYPE_LO) begin
            st_d = ({etype_hi_q, bus.data} == ETHERTYPE_IPV4) ? StIp : StDrop;
          end
        end

        StIp: begin
          if (cur_off == OFF_IP_VIHL) begin
            ihl_d = bus.data[3:0];
            if (bus.data[7:4] != IP_VERSION_4 || bus.data[3:0] < MIN_HDR_WORDS) begin
              st_d = StDrop;
            end
          end
          if (cur_off == OFF_IP_LEN_HI) tot_len_d[15:8] = bus.data;
          if (cur_off == OFF_IP_LEN_LO) tot_len_d[7:0]  = bus.data;
          if (cur_off == OFF_IP_PROTO && bus.data != IP_PROTO_TCP) st_d = StDrop;
          if (cur_off >= OFF_IP_SRC_FST && cur_off <= OFF_IP_SRC_LST) begin
            cap_d.src_ip = {cap_q.src_ip[23:0], bus.data};
          end
          if (cur_off >= OFF_IP_DST_FST && cur_off <= OFF_IP_DST_LST) begin
            cap_d.dst_ip = {cap_q.dst_ip[23:0], bus.data};
          end
          // Last byte of the IP header (options included) hands over to TCP
          if (cur_off > OFF_IP_VIHL && cur_off == tcp_start - 16'd1) st_d = StTcp;
        end

        StTcp: begin
          if (tcp_rel == TCP_SPORT_HI) cap_d.src_port[15:8] = bus.data;
          if (tcp_rel == TCP_SPORT_LO) cap_d.src_port[7:0]  = bus.data;
          if (tcp_rel == TCP_DPORT_HI) cap_d.dst_port[15:8] = bus.data;
          if (tcp_rel == TCP_DPORT_LO) cap_d.dst_port[7:0]  = bus.data;
          if (tcp_rel == TCP_DOFF) begin
            doff_d = bus.data[7:4];
            if (bus.data[7:4] < MIN_HDR_WORDS) st_d = StDrop;
          end
          // doff_q is only meaningful once the data-offset byte has gone by
          if (tcp_rel > TCP_DOFF && cur_off == payload_start - 16'd1) st_d = StPayload;
        end

        StPayload: begin
          // Bytes past ip_end are Ethernet padding; a saturated offset is out of range
          if ({1'b0, cur_off} < ip_end && cur_off != OFF_MAX) begin
            out_data_d = bus.data;
            out_a_d    = match_a;
            out_b_d    = match_b;
          end else begin
            st_d = StDrop;
          end
        end

        default: ;
      endcase
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge CLOCK) begin
    if (reset) begin
      st_q       <= StIdle;
      off_q      <= '0;
      etype_hi_q <= '0;
      ihl_q      <= '0;
      tot_len_q  <= '0;
      doff_q     <= '0;
      cap_q      <= '0;
      out_data_q <= '0;
      out_a_q    <= 1'b0;
      out_b_q    <= 1'b0;
    end else begin
      st_q       <= st_d;
      off_q      <= off_d;
      etype_hi_q <= etype_hi_d;
      ihl_q      <= ihl_d;
      tot_len_q  <= tot_len_d;
      doff_q     <= doff_d;
      cap_q      <= cap_d;
      out_data_q <= out_data_d;
      out_a_q    <= out_a_d;
      out_b_q    <= out_b_d;
    end
  end

  assign bus.outData       = out_data_q;
  assign bus.outDataMatchA = out_a_q;
  assign bus.outDataMatchB = out_b_q;

endmodule

// File: tb/tb_tcp.sv
// Bench for the tcp payload extractor: directed frames from the test plan plus
// random frames, checked per cycle against a whole-frame reference model.
module tb_tcp;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a_sip, a_dip, b_sip, b_dip;
  logic [15:0] a_sp, a_dp, b_sp, b_dp;

  tcp_if bus ();

  tcp #(
    .port (16'd80),
    .mac  (48'h000000000000)
  ) dut (
    .CLOCK         (clk),
    .reset         (rst),
    .tcpA_src_ip   (a_sip),
    .tcpA_src_port (a_sp),
    .tcpA_dst_ip   (a_dip),
    .tcpA_dst_port (a_dp),
    .tcpB_src_ip   (b_sip),
    .tcpB_src_port (b_sp),
    .tcpB_dst_ip   (b_dip),
    .tcpB_dst_port (b_dp),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] CLI_IP   = 32'h0AD2321C;  // 10.210.50.28
  localparam logic [31:0] SRV_IP   = 32'h0AD2900B;  // 10.210.144.11
  localparam logic [15:0] CLI_PORT = 16'd57284;
  localparam logic [15:0] SRV_PORT = 16'd4846;

  int         checks = 0;
  int         failures = 0;
  int         cnt_a = 0;
  int         cnt_b = 0;
  logic [7:0] frame [$];
  logic [7:0] pl_q [$];
  bit         exp_emit [$];
  bit         exp_a, exp_b;
  logic [7:0] last_out = 8'h00;

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: drive a byte (or idle), then check outputs one cycle later.
  task automatic tick(input logic v, input logic [7:0] b, input logic np, input bit e);
    @(negedge clk);
    bus.dataValid = v;
    bus.data      = b;
    bus.newpkt    = np;
    @(posedge clk);
    #1;
    bus.dataValid = 1'b0;
    bus.newpkt    = 1'b0;
    if (e) last_out = b;
    if (bus.outDataMatchA === 1'b1) cnt_a++;
    if (bus.outDataMatchB === 1'b1) cnt_b++;
    check1("strobeA", bus.outDataMatchA, e && exp_a);
    check1("strobeB", bus.outDataMatchB, e && exp_b);
    check8("outData", bus.outData, last_out);
  endtask

  task automatic push32(input logic [31:0] w);
    for (int k = 3; k >= 0; k--) frame.push_back(w[8*k +: 8]);
  endtask

  task automatic push16(input logic [15:0] w);
    frame.push_back(w[15:8]);
    frame.push_back(w[7:0]);
  endtask

  // Assemble an Ethernet/IPv4/TCP frame carrying pl_q, padded with random bytes.
  task automatic build(input logic [31:0] sip, input logic [15:0] sp, input logic [31:0] dip,
                       input logic [15:0] dp, input int ihl, input int doff,
                       input logic [15:0] etype, input logic [7:0] proto, input int pad_to);
    int          tot;
    logic [31:0] ihl_w, doff_w;
    tot    = 4 * ihl + 4 * doff + pl_q.size();
    ihl_w  = ihl;
    doff_w = doff;
    frame.delete();
    for (int k = 0; k < 12; k++) frame.push_back(8'($urandom));
    push16(etype);
    frame.push_back({4'd4, ihl_w[3:0]});
    frame.push_back(8'h00);
    push16(16'(tot));
    push16(16'($urandom));
    push16(16'h4000);
    frame.push_back(8'd64);
    frame.push_back(proto);
    push16(16'($urandom));
    push32(sip);
    push32(dip);
    for (int k = 0; k < (ihl - 5) * 4; k++) frame.push_back(8'h01);
    push16(sp);
    push16(dp);
    push32($urandom);
    push32($urandom);
    frame.push_back({doff_w[3:0], 4'h0});
    frame.push_back(8'h18);
    push16(16'hFFFF);
    push16(16'($urandom));
    push16(16'h0000);
    for (int k = 0; k < (doff - 5) * 4; k++) frame.push_back(8'h01);
    foreach (pl_q[k]) frame.push_back(pl_q[k]);
    while (frame.size() < pad_to) frame.push_back(8'($urandom));
  endtask

  // Reference: parse the whole frame as a byte array and mark payload indices.
  function automatic void model();
    int          len, ihl, tot, ts, doff, ps, pe;
    logic [7:0]  vihl, doff_b;
    logic [31:0] sip, dip;
    logic [15:0] sp, dp;
    len = frame.size();
    exp_emit.delete();
    for (int i = 0; i < len; i++) exp_emit.push_back(1'b0);
    exp_a = 1'b0;
    exp_b = 1'b0;
    if (len < 34) return;
    if ({frame[12], frame[13]} != 16'h0800) return;
    vihl = frame[14];
    ihl  = int'(vihl[3:0]);
    if (vihl[7:4] != 4'd4 || ihl < 5) return;
    if (frame[23] != 8'd6) return;
    tot = int'({frame[16], frame[17]});
    ts  = 14 + 4 * ihl;
    if (len < ts + 13) return;
    doff_b = frame[ts + 12];
    doff   = int'(doff_b[7:4]);
    if (doff < 5) return;
    ps = ts + 4 * doff;
    pe = 14 + tot;
    if (pe > len) pe = len;
    if (pe > 65535) pe = 65535;
    for (int i = ps; i < pe; i++) exp_emit[i] = 1'b1;
    sip   = {frame[26], frame[27], frame[28], frame[29]};
    dip   = {frame[30], frame[31], frame[32], frame[33]};
    sp    = {frame[ts], frame[ts + 1]};
    dp    = {frame[ts + 2], frame[ts + 3]};
    exp_a = (sip == a_sip) && (sp == a_sp) && (dip == a_dip) && (dp == a_dp);
    exp_b = (sip == b_sip) && (sp == b_sp) && (dip == b_dip) && (dp == b_dp);
  endfunction

  // Send frame[lo..hi-1]; optional fixed gap before gap_at and random gaps.
  task automatic send_range(input int lo, input int hi, input bit live, input int gap_at,
                            input int gap_len, input int gap_pct);
    int g;
    for (int i = lo; i < hi; i++) begin
      g = (i == gap_at) ? gap_len : 0;
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) g += 1 + $urandom_range(2);
      for (int j = 0; j < g; j++) tick(1'b0, 8'($urandom), 1'b0, 1'b0);
      tick(1'b1, frame[i], (i == 0), live && exp_emit[i]);
    end
  endtask

  task automatic send_frame(input int gap_at, input int gap_len, input int gap_pct);
    model();
    send_range(0, frame.size(), 1'b1, gap_at, gap_len, gap_pct);
    tick(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic set_tuples(input logic [31:0] asip, input logic [15:0] asp,
                            input logic [31:0] adip, input logic [15:0] adp,
                            input logic [31:0] bsip, input logic [15:0] bsp,
                            input logic [31:0] bdip, input logic [15:0] bdp);
    a_sip = asip; a_sp = asp; a_dip = adip; a_dp = adp;
    b_sip = bsip; b_sp = bsp; b_dip = bdip; b_dp = bdp;
  endtask

  task automatic perturb(inout logic [31:0] sip, inout logic [15:0] sp,
                         inout logic [31:0] dip, inout logic [15:0] dp);
    case ($urandom_range(3))
      0: sip ^= 32'(1) << $urandom_range(31);
      1: sp  ^= 16'(1) << $urandom_range(15);
      2: dip ^= 32'(1) << $urandom_range(31);
      default: dp ^= 16'(1) << $urandom_range(15);
    endcase
  endtask

  logic [31:0] r_sip, r_dip, t_sip, t_dip;
  logic [15:0] r_sp, r_dp, t_sp, t_dp, r_et;
  logic [7:0]  r_pr;
  int          r_plen, r_ihl, r_doff, r_sel, r_n;

  initial begin
    bus.dataValid = 1'b0;
    bus.data      = 8'h00;
    bus.newpkt    = 1'b0;
    set_tuples(CLI_IP, CLI_PORT, SRV_IP, SRV_PORT, '0, '0, '0, '0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check1("reset strobeA", bus.outDataMatchA, 1'b0);
    check1("reset strobeB", bus.outDataMatchB, 1'b0);
    check8("reset outData", bus.outData, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // Single payload byte 0x20, tuple A only
    pl_q = '{8'h20};
    build(CLI_IP, CLI_PORT, SRV_IP, SRV_PORT, 5, 5, 16'h0800, 8'd6, 60);
    cnt_a = 0; cnt_b = 0;
    send_frame(-1, 0, 0);
    check_int("s1 pulsesA", cnt_a, 1);
    check_int("s1 pulsesB", cnt_b, 0);
    check8("s1 byte", bus.outData, 8'h20);

    // Same frame, tuple B set, A only carries the source port
    set_tuples('0, CLI_PORT, '0, '0, CLI_IP, CLI_PORT, SRV_IP, SRV_PORT);
    cnt_a = 0; cnt_b = 0;
    send_frame(-1, 0, 0);
    check_int("s2 pulsesA", cnt_a, 0);
    check_int("s2 pulsesB", cnt_b, 1);

    // Handshake and teardown without payload
    set_tuples(CLI_IP, CLI_PORT, SRV_IP, SRV_PORT, '0, '0, '0, '0);
    pl_q.delete();
    cnt_a = 0; cnt_b = 0;
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) build(CLI_IP, CLI_PORT, SRV_IP, SRV_PORT, 5, 5, 16'h0800, 8'd6, 60);
      else            build(SRV_IP, SRV_PORT, CLI_IP, CLI_PORT, 5, 5, 16'h0800, 8'd6, 60);
      send_frame(-1, 0, 0);
    end
    check_int("s3 pulsesA", cnt_a, 0);
    check_int("s3 pulsesB", cnt_b, 0);

    // Reverse direction, non-IPv4 ethertype, UDP protocol
    pl_q = '{8'h61, 8'h62};
    cnt_a = 0; cnt_b = 0;
    build(SRV_IP, SRV_PORT, CLI_IP, CLI_PORT, 5, 5, 16'h0800, 8'd6, 60);
    send_frame(-1, 0, 0);
    build(CLI_IP, CLI_PORT, SRV_IP, SRV_PORT, 5, 5, 16'h0806, 8'd6, 60);
    send_frame(-1, 0, 0);
    build(CLI_IP, CLI_PORT, SRV_IP, SRV_PORT, 5, 5, 16'h0800, 8'd17, 60);
    send_frame(-1, 0, 0);
    check_int("s4 pulsesA", cnt_a, 0);
    check_int("s4 pulsesB", cnt_b, 0);

    // IP options and TCP options: payload begins at 14+24+32 = 70
    pl_q = '{8'h78, 8'h79, 8'h7A};
    build(CLI_IP, CLI_PORT, SRV_IP, SRV_PORT, 6, 8, 16'h0800, 8'd6, 60);
    cnt_a = 0; cnt_b = 0;
    send_frame(-1, 0, 0);
    check_int("s5 pulsesA", cnt_a, 3);
    check8("s5 last byte", bus.outData, 8'h7A);

    // Three idle cycles inside the payload
    cnt_a = 0;
    send_frame(71, 3, 0);
    check_int("s6 gap pulsesA", cnt_a, 3);

    // Reset in the middle of the payload (payload at 54..56)
    build(CLI_IP, CLI_PORT, SRV_IP, SRV_PORT, 5, 5, 16'h0800, 8'd6, 60);
    model();
    send_range(0, 56, 1'b1, -1, 0, 0);
    check8("pre-reset byte", bus.outData, 8'h79);
    @(negedge clk);
    rst           = 1'b1;
    bus.dataValid = 1'b1;
    bus.data      = frame[56];
    @(posedge clk);
    #1;
    rst           = 1'b0;
    bus.dataValid = 1'b0;
    last_out      = 8'h00;
    check1("midrst strobeA", bus.outDataMatchA, 1'b0);
    check1("midrst strobeB", bus.outDataMatchB, 1'b0);
    check8("midrst outData", bus.outData, 8'h00);
    send_range(57, frame.size(), 1'b0, -1, 0, 0);
    cnt_a = 0;
    send_frame(-1, 0, 0);
    check_int("post-reset pulsesA", cnt_a, 3);

    // newpkt mid-payload aborts the frame and restarts on the same byte
    pl_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    build(CLI_IP, CLI_PORT, SRV_IP, SRV_PORT, 5, 5, 16'h0800, 8'd6, 60);
    model();
    cnt_a = 0;
    send_range(0, 57, 1'b1, -1, 0, 0);
    pl_q = '{8'h78, 8'h79, 8'h7A};
    build(CLI_IP, CLI_PORT, SRV_IP, SRV_PORT, 5, 5, 16'h0800, 8'd6, 60);
    send_frame(-1, 0, 0);
    check_int("abort pulsesA", cnt_a, 3 + 3);

    // Random frames against the reference model
    for (int n = 0; n < 40; n++) begin
      r_sip = $urandom; r_dip = $urandom;
      r_sp  = 16'($urandom); r_dp = 16'($urandom);
      r_sel = $urandom_range(3);
      t_sip = r_sip; t_sp = r_sp; t_dip = r_dip; t_dp = r_dp;
      if (!r_sel[0]) perturb(t_sip, t_sp, t_dip, t_dp);
      a_sip = t_sip; a_sp = t_sp; a_dip = t_dip; a_dp = t_dp;
      t_sip = r_sip; t_sp = r_sp; t_dip = r_dip; t_dp = r_dp;
      if (!r_sel[1]) perturb(t_sip, t_sp, t_dip, t_dp);
      b_sip = t_sip; b_sp = t_sp; b_dip = t_dip; b_dp = t_dp;
      r_plen = $urandom_range(12);
      pl_q.delete();
      for (int k = 0; k < r_plen; k++) pl_q.push_back(8'($urandom));
      r_ihl  = ($urandom_range(9) == 0) ? 4 : 5 + $urandom_range(2);
      r_doff = ($urandom_range(9) == 0) ? 4 : 5 + $urandom_range(4);
      r_et   = ($urandom_range(9) == 0) ? 16'h86DD : 16'h0800;
      r_pr   = ($urandom_range(9) == 0) ? 8'd17 : 8'd6;
      build(r_sip, r_sp, r_dip, r_dp, r_ihl, r_doff, r_et, r_pr, 60);
      model();
      r_n = ($urandom_range(7) == 0) ? $urandom_range(frame.size() - 1) : frame.size();
      send_range(0, r_n, 1'b1, -1, 0, 20);
      tick(1'b0, 8'h00, 1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tcp.md
Name: tcp

Overview:
- Byte-stream TCP payload extractor for Ethernet/IPv4 frames.
- Sits downstream of the frame source (PcapParser in simulation, MAC receive path in hardware), which delivers one frame byte per valid cycle.
- Classifies each frame against two runtime-configured TCP 4-tuples, A and B.
- Emits the TCP payload bytes of matching frames with a per-tuple match strobe.

Parameters:
- port, 80, nominal local TCP port; carried for configuration only, no effect on filtering in this revision.
- mac, 48'h000000000000, local MAC address; carried for configuration only, no destination-MAC filtering in this revision.

Ports:
- CLOCK  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- tcpA_src_ip  in  32  tuple A source IPv4 address (first octet in bits 31:24).
- tcpA_src_port  in  16  tuple A source port.
- tcpA_dst_ip  in  32  tuple A destination IPv4 address.
- tcpA_dst_port  in  16  tuple A destination port.
- tcpB_src_ip, tcpB_src_port, tcpB_dst_ip, tcpB_dst_port  in  32/16/32/16  tuple B, same encoding as A.
- dataValid  in  1  data carries a frame byte this cycle.
- data  in  8  frame byte, Ethernet destination MAC first.
- newpkt  in  1  one-cycle pulse coincident with the first valid byte of each frame.
- outDataMatchA  out  1  outData is a payload byte of a tuple-A frame.
- outDataMatchB  out  1  outData is a payload byte of a tuple-B frame.
- outData  out  8  registered payload byte.

Behaviour:
- Reset: all outputs 0, byte offset 0, state IDLE. Reset mid-frame discards the frame; parsing resumes at the next newpkt.
- Byte offset counter: 16 bits, saturating at 0xFFFF. newpkt with dataValid sets offset 0 and state ETH. The counter advances only on dataValid; cycles without dataValid hold all state and drive both strobes low.
- States:
  - ETH: offsets 0-13. Ethertype at 12-13 must be 0x0800, else DROP.
  - IP: offset 14 must have version 4 and IHL>=5, else DROP. Capture total length (16-17), protocol (23, must be 6, else DROP), source IP (26-29), destination IP (30-33). ip_end = 14 + total length.
  - TCP: starts at 14 + 4*IHL. Capture source port (+0,+1) and destination port (+2,+3). Data offset is the upper nibble of +12; it must be >=5, else DROP. payload_start = TCP start + 4*data offset.
  - PAYLOAD: bytes at offsets in [payload_start, ip_end).
  - DROP: ignore input until the next newpkt.
- Match evaluation:
  - matchA = captured src IP, src port, dst IP and dst port all equal tuple A. matchB is the same test against tuple B.
  - Both are evaluated once the TCP ports are captured and held for the rest of the frame.
  - A and B may both be true; both strobes then assert together.
- Output:
  - For each valid byte in PAYLOAD, on the next cycle outData = that byte, outDataMatchA = matchA, outDataMatchB = matchB. Latency is 1 cycle.
  - Otherwise both strobes are 0 and outData holds its last value.
- Boundaries:
  - Ethernet padding after ip_end is never emitted, so zero-payload SYN/ACK/FIN frames produce no strobes.
  - A frame truncated before payload_start emits nothing.
  - newpkt arriving mid-frame aborts the current frame and restarts at offset 0 on the same byte.
  - Offset saturation ends PAYLOAD.
  - Tuple inputs are sampled continuously and must be stable during a frame.

Decomposition:
- Shared package holds:
  - constants ETHERTYPE_IPV4=16'h0800, IP_PROTO_TCP=8'd6, ETH_HDR_LEN=14.
  - field offset localparams.
  - the state enum (IDLE, ETH, IP, TCP, PAYLOAD, DROP).
- One natural sub-module, tcp_tuple_match: compares the captured 4-tuple against one configured tuple. Instantiate it twice, for A and B.

Test Plan:
- Frame 10.210.50.28:57284 -> 10.210.144.11:4846 carrying 1 payload byte 0x20, padded to 60 bytes, with tuple A set to it and tuple B zero -> exactly one outDataMatchA pulse with outData=0x20; outDataMatchB never asserts.
- Same frame with tuple B set and tuple A zeroed except src port 57284 -> exactly one outDataMatchB pulse, 0x20; A silent.
- Full handshake plus FIN/ACK teardown with no payload, 60-byte padded frames -> zero strobes.
- Reverse-direction frame 4846 -> 57284 with payload "ab", tuples as in the first scenario -> zero strobes; ethertype 0x0806 or protocol 17 -> zero strobes.
- IHL=6 and TCP data offset 8, payload "xyz", tuple A match -> 3 strobes, bytes 0x78, 0x79, 0x7A in order, each 1 cycle after its input byte.
- dataValid deasserted for 3 cycles inside the payload -> same 3 bytes with gaps; reset asserted mid-payload -> strobes drop the next cycle, and the next matching frame parses correctly.
